mpls_stack_parser: RTL and testbench

Parametrised L2/L2.5 header walker for the trafparser chain. Captures the first header words of each packet from the 64-bit packet bus. Walks up to MAX_VLANS VLAN tags and up to MAX_LABELS MPLS labels, one field per cycle. Reports the label stack, VLAN count, L3 type and L3 byte offset as a per-packet result strobe; packet data passes through with one-cycle latency.

---
 rtl/mpls_stack_parser.sv | 221 ++++++++++++++++++++++
 tb/tb_mpls_stack_parser.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpls_stack_parser.sv
// mpls_stack_parser
//   Captures the first HDR_WORDS words of each packet, then walks VLAN tags
//   and the MPLS label stack one field per cycle. The result is a one-cycle
//   strobe (res_vld_o) carrying the label stack, VLAN count, L3 type and L3
//   byte offset. Packet data passes through with one cycle of latency.
// Ports
//   clk_i, srst_i           clock, synchronous active-high reset
//   en_i                    parse enable; when low, a sop starts no parse
//   pkt_*_i                 64-bit packet bus, byte 0 = [63:56], mod 0 = 8 bytes
//   pkt_*_o                 packet bus registered once
//   res_vld_o               result strobe; the result fields hold until the next one
//   vlan_cnt_o              VLAN tags found
//   mpls_label_o/en/cnt     label i at [32i+31:32i], valid mask, count
//   mpls_ovf_o              MAX_LABELS labels read without seeing BOS
//   l3_type_o, l3_ofs_o     00 none / 01 IPv4 / 10 IPv6, byte offset of L3
//   trunc_o                 captured bytes ran out before the walk finished
//   drop_o                  pulse: an in-flight parse was aborted by a new sop
module mpls_stack_parser #(
  parameter int MAX_VLANS  = 3,
  parameter int MAX_LABELS = 4,
  parameter int HDR_WORDS  = (18 + 4*MAX_VLANS + 4*MAX_LABELS + 7) / 8
) (
  input  logic                               clk_i,
  input  logic                               srst_i,
  input  logic                               en_i,
  input  logic [63:0]                        pkt_data_i,
  input  logic [2:0]                         pkt_mod_i,
  input  logic                               pkt_sop_i,
  input  logic                               pkt_eop_i,
  input  logic                               pkt_en_i,
  output logic [63:0]                        pkt_data_o,
  output logic [2:0]                         pkt_mod_o,
  output logic                               pkt_sop_o,
  output logic                               pkt_eop_o,
  output logic                               pkt_en_o,
  output logic                               res_vld_o,
  output logic [1:0]                         vlan_cnt_o,
  output logic [32*MAX_LABELS-1:0]           mpls_label_o,
  output logic [MAX_LABELS-1:0]              mpls_en_o,
  output logic [$clog2(MAX_LABELS+1)-1:0]    mpls_cnt_o,
  output logic                               mpls_ovf_o,
  output logic [1:0]                         l3_type_o,
  output logic [7:0]                         l3_ofs_o,
  output logic                               trunc_o,
  output logic                               drop_o
);
  localparam int CW = $clog2(MAX_LABELS+1);
  localparam int HB = HDR_WORDS * 8;

  typedef enum logic [2:0] {IDLE, CAPTURE, WALK, LABEL, DONE} state_t;

  // Byte a of the capture buffer; words are stored whole, byte 0 in the MSBs.
  function automatic logic [7:0] rd_byte(input logic [HDR_WORDS*64-1:0] h,
                                         input logic [7:0] a);
    rd_byte = '0;
    for (int i = 0; i < HB; i++)
      if (a == 8'(i)) rd_byte = h[(i/8)*64 + 63 - 8*(i%8) -: 8];
  endfunction

  state_t                     state_q, state_d;
  logic [HDR_WORDS*64-1:0]    hdr_q, hdr_d;
  logic [7:0]                 wcnt_q, wcnt_d, bcnt_q, bcnt_d, ptr_q, ptr_d;
  logic [1:0]                 vcnt_q, vcnt_d;
  logic [32*MAX_LABELS-1:0]   lbl_q, lbl_d;
  logic [MAX_LABELS-1:0]      men_q, men_d;
  logic [CW-1:0]              mcnt_q, mcnt_d;
  logic                       ovf_q, ovf_d, trunc_q, trunc_d;
  logic [1:0]                 l3t_q, l3t_d;
  logic [7:0]                 l3o_q, l3o_d;
  // registered outputs
  logic [63:0]                pd_q;
  logic [2:0]                 pm_q;
  logic                       ps_q, pe_q, pv_q, res_vld_q, drop_q;
  logic [1:0]                 o_vcnt_q, o_l3t_q;
  logic [32*MAX_LABELS-1:0]   o_lbl_q;
  logic [MAX_LABELS-1:0]      o_men_q;
  logic [CW-1:0]              o_mcnt_q;
  logic                       o_ovf_q, o_trunc_q;
  logic [7:0]                 o_l3o_q;

  logic        start, wr_en, wr_last, fin, drop;
  logic [7:0]  wr_idx, b0, b1, b2, b3, b4;
  logic [15:0] etype;
  logic [31:0] lword;
  logic [8:0]  end2, end4, end5;

  always_comb begin
    state_d = state_q; hdr_d = hdr_q; wcnt_d = wcnt_q; bcnt_d = bcnt_q;
    ptr_d = ptr_q; vcnt_d = vcnt_q; lbl_d = lbl_q; men_d = men_q;
    mcnt_d = mcnt_q; ovf_d = ovf_q; trunc_d = trunc_q; l3t_d = l3t_q;
    l3o_d = l3o_q; fin = 1'b0; drop = 1'b0;

    b0 = rd_byte(hdr_q, ptr_q);
    b1 = rd_byte(hdr_q, ptr_q + 8'd1);
    b2 = rd_byte(hdr_q, ptr_q + 8'd2);
    b3 = rd_byte(hdr_q, ptr_q + 8'd3);
    b4 = rd_byte(hdr_q, ptr_q + 8'd4);
    etype = {b0, b1};
    lword = {b0, b1, b2, b3};
    // one past the last byte each read touches, compared with captured bytes
    end2 = {1'b0, ptr_q} + 9'd2;
    end4 = {1'b0, ptr_q} + 9'd4;
    end5 = {1'b0, ptr_q} + 9'd5;

    start   = pkt_en_i & pkt_sop_i & en_i;
    wr_en   = start | (state_q == CAPTURE & pkt_en_i);
    wr_idx  = start ? 8'd0 : wcnt_q;
    wr_last = pkt_eop_i | (wr_idx == 8'(HDR_WORDS-1));

    case (state_q)
      WALK: begin
        if (end2 > {1'b0, bcnt_q}) begin
          trunc_d = 1'b1; fin = 1'b1;
        end else if ((etype == 16'h8100 || etype == 16'h88A8 || etype == 16'h9100)
                     && vcnt_q < 2'(MAX_VLANS)) begin
          vcnt_d = vcnt_q + 2'd1;
          ptr_d  = ptr_q + 8'd4;
        end else if (etype == 16'h8847 || etype == 16'h8848) begin
          ptr_d   = ptr_q + 8'd2;
          state_d = LABEL;
        end else begin
          l3t_d = (etype == 16'h0800) ? 2'b01 : (etype == 16'h86DD) ? 2'b10 : 2'b00;
          l3o_d = ptr_q + 8'd2;
          fin   = 1'b1;
        end
      end
      LABEL: begin
        if (end4 > {1'b0, bcnt_q}) begin
          trunc_d = 1'b1; fin = 1'b1;
        end else begin
          // mcnt doubles as the label index
          for (int i = 0; i < MAX_LABELS; i++)
            if (mcnt_q == CW'(i)) begin
              lbl_d[i*32 +: 32] = lword;
              men_d[i]          = 1'b1;
            end
          mcnt_d = mcnt_q + CW'(1);
          ptr_d  = ptr_q + 8'd4;
          if (lword[8]) begin
            // BOS: peek at the IP version nibble right after the stack
            if (end5 > {1'b0, bcnt_q}) trunc_d = 1'b1;
            else begin
              l3t_d = (b4[7:4] == 4'd4) ? 2'b01 : (b4[7:4] == 4'd6) ? 2'b10 : 2'b00;
              l3o_d = ptr_q + 8'd4;
            end
            fin = 1'b1;
          end else if (mcnt_q == CW'(MAX_LABELS-1)) begin
            ovf_d = 1'b1; fin = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase
    if (fin) state_d = DONE;

    // A new sop wins over anything in flight. In DONE the result is already
    // out, so only CAPTURE/WALK/LABEL count as a discarded parse.
    if (start) begin
      drop   = (state_q == CAPTURE) | (state_q == WALK) | (state_q == LABEL);
      fin    = 1'b0;
      vcnt_d = '0; lbl_d = '0; men_d = '0; mcnt_d = '0;
      ovf_d  = 1'b0; trunc_d = 1'b0; l3t_d = '0; l3o_d = '0;
    end
    if (wr_en) begin
      for (int w = 0; w < HDR_WORDS; w++)
        if (wr_idx == 8'(w)) hdr_d[w*64 +: 64] = pkt_data_i;
      wcnt_d = wr_idx + 8'd1;
      if (wr_last) begin
        bcnt_d  = (wr_idx << 3) + ((pkt_eop_i && pkt_mod_i != 3'd0) ? {5'd0, pkt_mod_i} : 8'd8);
        ptr_d   = 8'd12;
        vcnt_d  = '0;
        state_d = WALK;
      end else begin
        state_d = CAPTURE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE; hdr_q <= '0; wcnt_q <= '0; bcnt_q <= '0; ptr_q <= '0;
      vcnt_q <= '0; lbl_q <= '0; men_q <= '0; mcnt_q <= '0; ovf_q <= 1'b0;
      trunc_q <= 1'b0; l3t_q <= '0; l3o_q <= '0;
      pd_q <= '0; pm_q <= '0; ps_q <= 1'b0; pe_q <= 1'b0; pv_q <= 1'b0;
      res_vld_q <= 1'b0; drop_q <= 1'b0; o_vcnt_q <= '0; o_lbl_q <= '0;
      o_men_q <= '0; o_mcnt_q <= '0; o_ovf_q <= 1'b0; o_l3t_q <= '0;
      o_l3o_q <= '0; o_trunc_q <= 1'b0;
    end else begin
      state_q <= state_d; hdr_q <= hdr_d; wcnt_q <= wcnt_d; bcnt_q <= bcnt_d;
      ptr_q <= ptr_d; vcnt_q <= vcnt_d; lbl_q <= lbl_d; men_q <= men_d;
      mcnt_q <= mcnt_d; ovf_q <= ovf_d; trunc_q <= trunc_d; l3t_q <= l3t_d;
      l3o_q <= l3o_d;
      pd_q <= pkt_data_i; pm_q <= pkt_mod_i; ps_q <= pkt_sop_i;
      pe_q <= pkt_eop_i; pv_q <= pkt_en_i;
      res_vld_q <= fin; drop_q <= drop;
      // results land together with the strobe, i.e. during the DONE cycle
      if (fin) begin
        o_vcnt_q <= vcnt_d; o_lbl_q <= lbl_d; o_men_q <= men_d;
        o_mcnt_q <= mcnt_d; o_ovf_q <= ovf_d; o_l3t_q <= l3t_d;
        o_l3o_q <= l3o_d; o_trunc_q <= trunc_d;
      end
    end
  end

  assign pkt_data_o   = pd_q;
  assign pkt_mod_o    = pm_q;
  assign pkt_sop_o    = ps_q;
  assign pkt_eop_o    = pe_q;
  assign pkt_en_o     = pv_q;
  assign res_vld_o    = res_vld_q;
  assign drop_o       = drop_q;
  assign vlan_cnt_o   = o_vcnt_q;
  assign mpls_label_o = o_lbl_q;
  assign mpls_en_o    = o_men_q;
  assign mpls_cnt_o   = o_mcnt_q;
  assign mpls_ovf_o   = o_ovf_q;
  assign l3_type_o    = o_l3t_q;
  assign l3_ofs_o     = o_l3o_q;
  assign trunc_o      = o_trunc_q;
endmodule

// File: tb/tb_mpls_stack_parser.sv
module tb_mpls_stack_parser;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst_i = 1'b1, en_i = 1'b1;
  logic [63:0] pkt_data_i = '0;
  logic [2:0]  pkt_mod_i = '0;
  logic        pkt_sop_i = 1'b0, pkt_eop_i = 1'b0, pkt_en_i = 1'b0;
  logic [63:0] pkt_data_o;
  logic [2:0]  pkt_mod_o;
  logic        pkt_sop_o, pkt_eop_o, pkt_en_o, res_vld_o, mpls_ovf_o, trunc_o, drop_o;
  logic [1:0]  vlan_cnt_o, l3_type_o;
  logic [127:0] mpls_label_o;
  logic [3:0]  mpls_en_o;
  logic [2:0]  mpls_cnt_o;
  logic [7:0]  l3_ofs_o;

  mpls_stack_parser dut (
    .clk_i(clk), .srst_i(srst_i), .en_i(en_i),
    .pkt_data_i(pkt_data_i), .pkt_mod_i(pkt_mod_i), .pkt_sop_i(pkt_sop_i),
    .pkt_eop_i(pkt_eop_i), .pkt_en_i(pkt_en_i),
    .pkt_data_o(pkt_data_o), .pkt_mod_o(pkt_mod_o), .pkt_sop_o(pkt_sop_o),
    .pkt_eop_o(pkt_eop_o), .pkt_en_o(pkt_en_o),
    .res_vld_o(res_vld_o), .vlan_cnt_o(vlan_cnt_o), .mpls_label_o(mpls_label_o),
    .mpls_en_o(mpls_en_o), .mpls_cnt_o(mpls_cnt_o), .mpls_ovf_o(mpls_ovf_o),
    .l3_type_o(l3_type_o), .l3_ofs_o(l3_ofs_o), .trunc_o(trunc_o), .drop_o(drop_o)
  );

  int asserts = 0, fails = 0;
  int cyc = 0, res_cnt = 0, res_cyc = 0, drop_cnt = 0, drop_cyc = 0;
  int pt_err = 0, pt_chk = 0;
  bit pt_armed = 1'b0;
  logic [63:0] e_data = '0;
  logic [2:0]  e_mod = '0;
  logic        e_sop = 1'b0, e_eop = 1'b0, e_en = 1'b0;
  logic [7:0]  pb [2][64];

  // passthrough reference: inputs registered once, zero under reset
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pt_armed <= 1'b1;
    if (srst_i) begin
      e_data <= '0; e_mod <= '0; e_sop <= 1'b0; e_eop <= 1'b0; e_en <= 1'b0;
    end else begin
      e_data <= pkt_data_i; e_mod <= pkt_mod_i; e_sop <= pkt_sop_i;
      e_eop <= pkt_eop_i; e_en <= pkt_en_i;
    end
  end

  always @(negedge clk) begin
    if (pt_armed) begin
      pt_chk <= pt_chk + 1;
      if ({pkt_data_o, pkt_mod_o, pkt_sop_o, pkt_eop_o, pkt_en_o} !==
          {e_data, e_mod, e_sop, e_eop, e_en}) pt_err <= pt_err + 1;
    end
    if (res_vld_o) begin res_cnt <= res_cnt + 1; res_cyc <= cyc; end
    if (drop_o)    begin drop_cnt <= drop_cnt + 1; drop_cyc <= cyc; end
  end

  task automatic clr(input int sel);
    for (int i = 0; i < 64; i++) pb[sel][i] = (i < 12) ? 8'(160 + i) : 8'h00;
  endtask
  task automatic put16(input int sel, input int ofs, input logic [15:0] v);
    pb[sel][ofs] = v[15:8]; pb[sel][ofs+1] = v[7:0];
  endtask
  task automatic put32(input int sel, input int ofs, input logic [31:0] v);
    for (int k = 0; k < 4; k++) pb[sel][ofs+k] = v[31-8*k -: 8];
  endtask

  task automatic drive_word(input int sel, input int nb, input int w);
    logic [63:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) if (w*8 + k < nb) d[63-8*k -: 8] = pb[sel][w*8+k];
    pkt_data_i = d; pkt_mod_i = 3'(nb % 8);
    pkt_sop_i = (w == 0); pkt_eop_i = (w == (nb + 7)/8 - 1); pkt_en_i = 1'b1;
  endtask

  // words go out on consecutive cycles; sc is the cycle the sop word is driven
  task automatic send(input int sel, input int nb, input bit en, output int sc);
    sc = 0;
    for (int w = 0; w < (nb + 7)/8; w++) begin
      @(negedge clk);
      if (w == 0) sc = cyc;
      drive_word(sel, nb, w);
      en_i = en;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pkt_en_i = 1'b0; pkt_sop_i = 1'b0; pkt_eop_i = 1'b0; pkt_data_i = '0; en_i = 1'b1;
    end
  endtask

  task automatic test_reset;
    srst_i = 1'b1;
    repeat (3) @(negedge clk);
    asserts++; if (res_vld_o !== 1'b0) begin fails++; $display("FAIL reset res_vld got %b exp 0", res_vld_o); end
    asserts++; if (drop_o !== 1'b0) begin fails++; $display("FAIL reset drop got %b exp 0", drop_o); end
    asserts++; if (mpls_label_o !== 128'd0) begin fails++; $display("FAIL reset labels got %h exp 0", mpls_label_o); end
    asserts++; if ({vlan_cnt_o, mpls_en_o, mpls_cnt_o, mpls_ovf_o, l3_type_o, l3_ofs_o, trunc_o} !== 21'd0) begin
      fails++; $display("FAIL reset fields got %h exp 0", {vlan_cnt_o, mpls_en_o, mpls_cnt_o, mpls_ovf_o, l3_type_o, l3_ofs_o, trunc_o}); end
    asserts++; if ({pkt_data_o, pkt_en_o, pkt_sop_o} !== 66'd0) begin fails++; $display("FAIL reset pkt_o got %h exp 0", {pkt_data_o, pkt_en_o, pkt_sop_o}); end
    srst_i = 1'b0;
  endtask

  task automatic test_ipv4;
    int sc, rb;
    clr(0); put16(0, 12, 16'h0800); pb[0][14] = 8'h45;
    rb = res_cnt;
    send(0, 64, 1'b1, sc); idle(12);
    asserts++; if (res_cnt - rb !== 1) begin fails++; $display("FAIL ipv4 res count got %0d exp 1", res_cnt - rb); end
    asserts++; if (res_cyc - sc !== 7) begin fails++; $display("FAIL ipv4 latency got %0d exp 7", res_cyc - sc); end
    asserts++; if (vlan_cnt_o !== 2'd0) begin fails++; $display("FAIL ipv4 vlan_cnt got %0d exp 0", vlan_cnt_o); end
    asserts++; if (mpls_cnt_o !== 3'd0) begin fails++; $display("FAIL ipv4 mpls_cnt got %0d exp 0", mpls_cnt_o); end
    asserts++; if (l3_type_o !== 2'b01) begin fails++; $display("FAIL ipv4 l3_type got %b exp 01", l3_type_o); end
    asserts++; if (l3_ofs_o !== 8'd14) begin fails++; $display("FAIL ipv4 l3_ofs got %0d exp 14", l3_ofs_o); end
    asserts++; if ({trunc_o, mpls_ovf_o} !== 2'b00) begin fails++; $display("FAIL ipv4 trunc/ovf got %b exp 00", {trunc_o, mpls_ovf_o}); end
  endtask

  task automatic test_vlan_mpls;
    int sc, rb;
    clr(0); put16(0, 12, 16'h8100); put16(0, 14, 16'h0005); put16(0, 16, 16'h8847);
    put32(0, 18, 32'h00064040); put32(0, 22, 32'h00065140); pb[0][26] = 8'h45;
    rb = res_cnt;
    send(0, 64, 1'b1, sc); idle(12);
    asserts++; if (res_cnt - rb !== 1) begin fails++; $display("FAIL vlan_mpls res count got %0d exp 1", res_cnt - rb); end
    asserts++; if (res_cyc - sc !== 10) begin fails++; $display("FAIL vlan_mpls latency got %0d exp 10", res_cyc - sc); end
    asserts++; if (vlan_cnt_o !== 2'd1) begin fails++; $display("FAIL vlan_mpls vlan_cnt got %0d exp 1", vlan_cnt_o); end
    asserts++; if (mpls_en_o !== 4'b0011) begin fails++; $display("FAIL vlan_mpls mpls_en got %b exp 0011", mpls_en_o); end
    asserts++; if (mpls_cnt_o !== 3'd2) begin fails++; $display("FAIL vlan_mpls mpls_cnt got %0d exp 2", mpls_cnt_o); end
    asserts++; if (mpls_label_o !== {64'd0, 32'h00065140, 32'h00064040}) begin fails++; $display("FAIL vlan_mpls labels got %h exp %h", mpls_label_o, {64'd0, 32'h00065140, 32'h00064040}); end
    asserts++; if (l3_type_o !== 2'b01) begin fails++; $display("FAIL vlan_mpls l3_type got %b exp 01", l3_type_o); end
    asserts++; if (l3_ofs_o !== 8'd26) begin fails++; $display("FAIL vlan_mpls l3_ofs got %0d exp 26", l3_ofs_o); end
    asserts++; if (mpls_ovf_o !== 1'b0) begin fails++; $display("FAIL vlan_mpls ovf got %b exp 0", mpls_ovf_o); end
  endtask

  task automatic test_ovf;
    int sc, rb;
    clr(0); put16(0, 12, 16'h8100); put16(0, 14, 16'h0001); put16(0, 16, 16'h88A8);
    put16(0, 18, 16'h0002); put16(0, 20, 16'h9100); put16(0, 22, 16'h0003);
    put16(0, 24, 16'h8847);
    for (int i = 0; i < 5; i++) put32(0, 26 + 4*i, 32'h00001040 + 32'(i) * 32'h1000);
    rb = res_cnt;
    send(0, 64, 1'b1, sc); idle(16);
    asserts++; if (res_cyc - sc !== 14) begin fails++; $display("FAIL ovf latency got %0d exp 14", res_cyc - sc); end
    asserts++; if (res_cnt - rb !== 1) begin fails++; $display("FAIL ovf res count got %0d exp 1", res_cnt - rb); end
    asserts++; if (vlan_cnt_o !== 2'd3) begin fails++; $display("FAIL ovf vlan_cnt got %0d exp 3", vlan_cnt_o); end
    asserts++; if (mpls_cnt_o !== 3'd4) begin fails++; $display("FAIL ovf mpls_cnt got %0d exp 4", mpls_cnt_o); end
    asserts++; if (mpls_ovf_o !== 1'b1) begin fails++; $display("FAIL ovf flag got %b exp 1", mpls_ovf_o); end
    asserts++; if (mpls_en_o !== 4'b1111) begin fails++; $display("FAIL ovf mpls_en got %b exp 1111", mpls_en_o); end
    asserts++; if (mpls_label_o[127:96] !== 32'h00004040) begin fails++; $display("FAIL ovf label3 got %h exp 00004040", mpls_label_o[127:96]); end
    asserts++; if ({l3_type_o, l3_ofs_o} !== 10'd0) begin fails++; $display("FAIL ovf l3 got %b/%0d exp 00/0", l3_type_o, l3_ofs_o); end
  endtask

  task automatic test_trunc;
    int sc, rb;
    clr(0); put16(0, 12, 16'h8100); put16(0, 14, 16'h0007); put16(0, 16, 16'h8847);
    put16(0, 18, 16'h0001);
    rb = res_cnt;
    send(0, 20, 1'b1, sc); idle(12);
    asserts++; if (res_cnt - rb !== 1) begin fails++; $display("FAIL trunc res count got %0d exp 1", res_cnt - rb); end
    asserts++; if (res_cyc - sc !== 6) begin fails++; $display("FAIL trunc latency got %0d exp 6", res_cyc - sc); end
    asserts++; if (trunc_o !== 1'b1) begin fails++; $display("FAIL trunc flag got %b exp 1", trunc_o); end
    asserts++; if ({mpls_cnt_o, mpls_en_o} !== 7'd0) begin fails++; $display("FAIL trunc mpls got %0d/%b exp 0/0000", mpls_cnt_o, mpls_en_o); end
    asserts++; if (vlan_cnt_o !== 2'd1) begin fails++; $display("FAIL trunc vlan_cnt got %0d exp 1", vlan_cnt_o); end
    asserts++; if ({l3_type_o, l3_ofs_o, mpls_ovf_o} !== 11'd0) begin fails++; $display("FAIL trunc l3 got %b/%0d exp 00/0", l3_type_o, l3_ofs_o); end
  endtask

  task automatic test_drop;
    int sa, sb, rb, db;
    clr(0); put16(0, 12, 16'h8100); put16(0, 14, 16'h0005); put16(0, 16, 16'h0800);
    clr(1); put16(1, 12, 16'h86DD); pb[1][14] = 8'h60;
    rb = res_cnt; db = drop_cnt;
    send(0, 48, 1'b1, sa);
    send(1, 64, 1'b1, sb);
    idle(12);
    asserts++; if (drop_cnt - db !== 1) begin fails++; $display("FAIL drop count got %0d exp 1", drop_cnt - db); end
    asserts++; if (drop_cyc - sa !== 7) begin fails++; $display("FAIL drop timing got %0d exp 7", drop_cyc - sa); end
    asserts++; if (res_cnt - rb !== 1) begin fails++; $display("FAIL drop res count got %0d exp 1", res_cnt - rb); end
    asserts++; if (res_cyc - sb !== 7) begin fails++; $display("FAIL drop new latency got %0d exp 7", res_cyc - sb); end
    asserts++; if (l3_type_o !== 2'b10) begin fails++; $display("FAIL drop l3_type got %b exp 10", l3_type_o); end
    asserts++; if (l3_ofs_o !== 8'd14) begin fails++; $display("FAIL drop l3_ofs got %0d exp 14", l3_ofs_o); end
    asserts++; if (vlan_cnt_o !== 2'd0) begin fails++; $display("FAIL drop vlan_cnt got %0d exp 0", vlan_cnt_o); end
  endtask

  task automatic test_srst_capture;
    int rb;
    clr(0); put16(0, 12, 16'h0800); pb[0][14] = 8'h45;
    rb = res_cnt;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      if (w == 3) begin
        asserts++; if ({res_vld_o, pkt_en_o, pkt_data_o} !== 66'd0) begin fails++; $display("FAIL srst pkt/res got %h exp 0", {res_vld_o, pkt_en_o, pkt_data_o}); end
        asserts++; if ({l3_type_o, l3_ofs_o, vlan_cnt_o} !== 12'd0) begin fails++; $display("FAIL srst results got %h exp 0", {l3_type_o, l3_ofs_o, vlan_cnt_o}); end
      end
      drive_word(0, 64, w);
      srst_i = (w == 2);
    end
    idle(15);
    asserts++; if (res_cnt - rb !== 0) begin fails++; $display("FAIL srst res count got %0d exp 0", res_cnt - rb); end
  endtask

  task automatic test_en_off;
    int sc, rb, db;
    clr(0); put16(0, 12, 16'h0800);
    rb = res_cnt; db = drop_cnt;
    send(0, 64, 1'b0, sc); idle(12);
    asserts++; if (res_cnt - rb !== 0) begin fails++; $display("FAIL en_off res count got %0d exp 0", res_cnt - rb); end
    asserts++; if (drop_cnt - db !== 0) begin fails++; $display("FAIL en_off drop count got %0d exp 0", drop_cnt - db); end
  endtask

  task automatic test_passthrough;
    asserts++; if (pt_err !== 0) begin fails++; $display("FAIL passthrough cycles wrong %0d exp 0", pt_err); end
    asserts++; if (pt_chk < 100) begin fails++; $display("FAIL passthrough cycles seen %0d exp >=100", pt_chk); end
  endtask

  initial begin
    test_reset();
    test_ipv4();
    test_vlan_mpls();
    test_ovf();
    test_trunc();
    test_drop();
    test_srst_capture();
    test_en_off();
    test_passthrough();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
